// File: rtl/pspin_host_direct_engine.sv
// HostDirect command engine: turns each command into one single-beat AXI access on the host port.
// Optional: define PSPIN_HOST_DIRECT_ERR_EN to add err_o and zero read data on error responses.
package pspin_host_direct_pkg;
  localparam int unsigned AXI_IW      = 6;
  localparam int unsigned AXI_WIDE_DW = 512;
  localparam int unsigned HOST_ADDR_W = 64;

  typedef logic [11:0] pspin_cmd_id_t;

  typedef enum logic [1:0] {
    HostMem    = 2'd0,
    HostDirect = 2'd1,
    NicSend    = 2'd2
  } pspin_cmd_type_t;

  typedef struct packed {
    logic                   nic_to_host;
    logic [HOST_ADDR_W-1:0] host_addr;
    logic [7:0]             imm_data_size;
    logic [AXI_WIDE_DW-1:0] imm_data;
  } host_direct_cmd_t;

  typedef struct packed {
    pspin_cmd_id_t    cmd_id;
    logic             generate_event;
    pspin_cmd_type_t  cmd_type;
    host_direct_cmd_t descr;
  } pspin_cmd_t;

  typedef struct packed {
    pspin_cmd_id_t          cmd_id;
    logic [AXI_WIDE_DW-1:0] imm_data;
  } pspin_cmd_resp_t;

  typedef struct packed {
    logic [AXI_IW-1:0]      id;
    logic [HOST_ADDR_W-1:0] addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic                   lock;
    logic [3:0]             cache;
    logic [2:0]             prot;
    logic [3:0]             qos;
    logic [3:0]             region;
    logic                   user;
  } host_ax_t;

  typedef struct packed {
    logic [AXI_WIDE_DW-1:0]   data;
    logic [AXI_WIDE_DW/8-1:0] strb;
    logic                     last;
    logic                     user;
  } host_w_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [1:0]        resp;
    logic              user;
  } host_b_t;

  typedef struct packed {
    logic [AXI_IW-1:0]      id;
    logic [AXI_WIDE_DW-1:0] data;
    logic [1:0]             resp;
    logic                   last;
    logic                   user;
  } host_r_t;

  typedef struct packed {
    host_ax_t aw;
    logic     aw_valid;
    host_w_t  w;
    logic     w_valid;
    logic     b_ready;
    host_ax_t ar;
    logic     ar_valid;
    logic     r_ready;
  } host_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    host_b_t b;
    logic    r_valid;
    host_r_t r;
  } host_resp_t;
endpackage

module pspin_host_direct_engine
  import pspin_host_direct_pkg::*;
#(
  parameter logic [AXI_IW-1:0] AXI_ID  = '0,
  parameter int unsigned       AXI_DW  = 512,
  parameter int unsigned       HOST_AW = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  pspin_cmd_t      cmd_i,
  output logic            cmd_resp_valid_o,
  input  logic            cmd_resp_ready_i,
  output pspin_cmd_resp_t cmd_resp_o,
  output host_req_t       host_req_o,
  input  host_resp_t      host_resp_i
`ifdef PSPIN_HOST_DIRECT_ERR_EN
  ,
  output logic            err_o
`endif
);

  localparam int unsigned NumBytes = AXI_DW / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned CntW     = OffW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StWrIssue,
    StWrResp,
    StRdIssue,
    StRdData,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic                aw_valid_q, aw_valid_d;
  logic                w_valid_q, w_valid_d;
  logic                ar_valid_q, ar_valid_d;
  logic                accept, b_fire, r_fire, b_ready, r_ready;

  pspin_cmd_id_t       cmd_id_q;
  logic [HOST_AW-1:0]  addr_q;
  logic [AXI_DW-1:0]   imm_q;
  logic [CntW-1:0]     n_q;
  logic                gen_q;
  logic [OffW-1:0]     off_q;

  logic [7:0]          size_in;
  logic [CntW-1:0]     room, n_raw, n_in;
  logic [AXI_DW-1:0]   wdata, rshift, rdata;
  logic [NumBytes-1:0] wstrb;
  host_ax_t            ax;

  assign off_q = addr_q[OffW-1:0];

  // Byte count is clamped to the bus width and then to what fits before the next line boundary.
  always_comb begin
    size_in = cmd_i.descr.imm_data_size;
    room    = CntW'(NumBytes) - CntW'(cmd_i.descr.host_addr[OffW-1:0]);
    if (size_in == 8'd0 || size_in > 8'(NumBytes)) begin
      n_raw = CntW'(NumBytes);
    end else begin
      n_raw = size_in[CntW-1:0];
    end
    n_in = (n_raw < room) ? n_raw : room;
  end

  always_comb begin
    wdata  = imm_q << {off_q, 3'b000};
    rshift = host_resp_i.r.data >> {off_q, 3'b000};
    wstrb  = '0;
    rdata  = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      wstrb[i] = (CntW'(i) >= CntW'(off_q)) && (CntW'(i) < CntW'(off_q) + n_q);
      rdata[8*i +: 8] = (CntW'(i) < n_q) ? rshift[8*i +: 8] : 8'h00;
    end
`ifdef PSPIN_HOST_DIRECT_ERR_EN
    if (host_resp_i.r.resp != 2'b00) begin
      rdata = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    aw_valid_d       = aw_valid_q;
    w_valid_d        = w_valid_q;
    ar_valid_d       = ar_valid_q;
    cmd_ready_o      = 1'b0;
    cmd_resp_valid_o = 1'b0;
    accept           = 1'b0;
    b_fire           = 1'b0;
    r_fire           = 1'b0;
    b_ready          = 1'b0;
    r_ready          = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          accept = 1'b1;
          if (cmd_i.descr.nic_to_host) begin
            state_d    = StWrIssue;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = StRdIssue;
            ar_valid_d = 1'b1;
          end
        end
      end
      StWrIssue: begin
        if (aw_valid_q && host_resp_i.aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && host_resp_i.w_ready) w_valid_d = 1'b0;
        if (!aw_valid_d && !w_valid_d) state_d = StWrResp;
      end
      StWrResp: begin
        b_ready = 1'b1;
        if (host_resp_i.b_valid) begin
          b_fire  = 1'b1;
          state_d = StResp;
        end
      end
      StRdIssue: begin
        if (ar_valid_q && host_resp_i.ar_ready) begin
          ar_valid_d = 1'b0;
          state_d    = StRdData;
        end
      end
      StRdData: begin
        r_ready = 1'b1;
        if (host_resp_i.r_valid && host_resp_i.r.last) begin
          r_fire  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        // Without generate_event the command retires silently.
        cmd_resp_valid_o = gen_q;
        if (!gen_q || cmd_resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
    end else begin
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_id_q <= '0;
      addr_q   <= '0;
      imm_q    <= '0;
      n_q      <= '0;
      gen_q    <= 1'b0;
    end else if (accept) begin
      cmd_id_q <= cmd_i.cmd_id;
      addr_q   <= cmd_i.descr.host_addr;
      imm_q    <= cmd_i.descr.imm_data;
      n_q      <= n_in;
      gen_q    <= cmd_i.generate_event;
    end else if (b_fire) begin
      imm_q <= '0;
    end else if (r_fire) begin
      imm_q <= rdata;
    end
  end

`ifdef PSPIN_HOST_DIRECT_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (b_fire && host_resp_i.b.resp != 2'b00) || (r_fire && host_resp_i.r.resp != 2'b00);
    end
  end

  assign err_o = err_q;
`endif

  assign cmd_resp_o.cmd_id   = cmd_id_q;
  assign cmd_resp_o.imm_data = imm_q;

  always_comb begin
    ax       = '0;
    ax.id    = AXI_ID;
    ax.addr  = {addr_q[HOST_AW-1:OffW], {OffW{1'b0}}};
    ax.len   = 8'd0;
    ax.size  = 3'($clog2(NumBytes));
    ax.burst = 2'b01;

    host_req_o          = '0;
    host_req_o.aw       = ax;
    host_req_o.aw_valid = aw_valid_q;
    host_req_o.w.data   = wdata;
    host_req_o.w.strb   = wstrb;
    host_req_o.w.last   = 1'b1;
    host_req_o.w_valid  = w_valid_q;
    host_req_o.b_ready  = b_ready;
    host_req_o.ar       = ax;
    host_req_o.ar_valid = ar_valid_q;
    host_req_o.r_ready  = r_ready;
  end

  logic unused_bits;
  assign unused_bits = ^{host_resp_i.b, host_resp_i.r.id, host_resp_i.r.resp, host_resp_i.r.user,
                         cmd_i.cmd_type};

endmodule

// File: doc/pspin_host_direct_engine.md
Name: pspin_host_direct_engine

Overview:
- Executes HostDirect commands (pspin_cmd_t with cmd_type==HostDirect) issued by HPUs through the command unit on interface CMD_HOSTDIRECT_ID.
- Each command becomes one single-beat AXI transaction on the 64-bit-address host port: a write when nic_to_host=1, a read when nic_to_host=0.
- Completion is returned as a pspin_cmd_resp_t carrying the original cmd_id. For reads, the response also carries the fetched immediate data.
- One command is in flight at a time.

Parameters:
- AXI_ID, 0, AXI ID driven on AW/AR (width AXI_IW=6).
- AXI_DW, 512, host data width in bits; must equal AXI_WIDE_DW.
- HOST_AW, 64, host address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&&ready.
- cmd_i  in  pspin_cmd_t  command; descr is read as host_direct_cmd_t.
- cmd_resp_valid_o  out  1  completion valid.
- cmd_resp_ready_i  in  1  completion consumer ready.
- cmd_resp_o  out  pspin_cmd_resp_t  {cmd_id, imm_data}.
- host_req_o  out  host_req_t  AXI master request to host.
- host_resp_i  in  host_resp_t  AXI response from host.

Behaviour:
- Reset values: cmd_ready_o=1, cmd_resp_valid_o=0, cmd_resp_o=0, all host_req_o valids and ready fields =0, FSM=Idle. Reset mid-transaction abandons it with no response. Host-side recovery is out of scope.
- Reset of inputs/outputs is asynchronous; all other state changes occur on the rising edge of clk_i.
- FSM states: Idle, WrIssue, WrResp, RdIssue, RdData, Resp.
- Idle: cmd_ready_o=1. On acceptance, latch cmd_id, host_addr, nic_to_host, imm_data, imm_data_size and generate_event.
  - nic_to_host=1 → WrIssue.
  - nic_to_host=0 → RdIssue.
  - cmd_ready_o=0 in every state other than Idle.
- Byte count: n = imm_data_size, with 0 or >64 clamped to 64.
  - Offset o = host_addr[5:0]; effective n = min(n, 64-o). Transfers never cross a 64 B boundary; excess bytes are silently dropped.
- AW/AR fields: addr = {host_addr[63:6], 6'b0}, len=0, size=3'd6, burst=INCR, id=AXI_ID, cache=0, prot=0, user=0.
- WrIssue:
  - aw_valid and w_valid are asserted in the same cycle after entry; each deasserts independently after its handshake.
  - w.data = imm_data << (8*o); w.strb has bits [o, o+n-1] set; w.last=1.
  - Both handshakes done → WrResp.
- WrResp: b_ready=1. On b_valid → Resp; bresp is ignored (see optional feature).
- RdIssue: ar_valid=1 until handshake → RdData.
- RdData: r_ready=1. On r_valid, capture imm_data = (r.data >> 8*o) with bytes ≥ n zeroed → Resp. r.last is required; rid is not checked.
- Resp:
  - generate_event=1: cmd_resp_valid_o=1, held stable until cmd_resp_ready_i → Idle. For writes, imm_data=0.
  - generate_event=0: no response is emitted → Idle in one cycle.
- Valid never depends combinationally on ready. Back-to-back commands are accepted no sooner than the cycle after returning to Idle.
- Latency, best case with zero-wait host, accept-to-resp_valid: write 3 cycles, read 3 cycles.

Optional Feature:
- Macro PSPIN_HOST_DIRECT_ERR_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0), pulsed high for exactly one cycle when bresp or rresp ≠ OKAY.
  - On a read error, imm_data is forced to all-zero.
  - The response is still issued per generate_event.
- Undefined: err_o does not exist; resp codes are ignored and read data is passed through unchanged.

Test Plan:
- Write, host_addr=0x1_0000_0040, size=8, imm_data=0x1122334455667788, generate_event=1 → AW addr 0x1_0000_0040, strb=0xFF, data[63:0]=0x1122334455667788, single resp with the same cmd_id and imm_data=0.
- Unaligned write, host_addr=0x...3C, size=16 → effective n=4; strb bits [63:60] set; data bytes 60..63 = imm bytes 0..3.
- Read, host_addr=0x...08, size=4, host returns data bytes 8..11 = 0xDEADBEEF → resp imm_data = 0x00..00DEADBEEF.
- Write with aw_ready held low 5 cycles while w_ready=1 → W completes first, AW completes later, exactly one B is accepted, cmd_ready_o stays 0 throughout.
- generate_event=0 read → AXI read occurs, cmd_resp_valid_o stays 0, cmd_ready_o returns to 1; a second command is accepted immediately after.
- Reset asserted during RdData, then released → all valids 0, cmd_ready_o=1; a fresh command completes normally. With PSPIN_HOST_DIRECT_ERR_EN, rresp=SLVERR → err_o one-cycle pulse and imm_data=0.
